// File: rtl/mem_stage_param.sv
// MEM stage with MEM/WB register: byte/half/word loads and stores, misalignment
// detection, and an optional multi-cycle data-memory latency with upstream stall.
module mem_stage_param #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        RegWrite_in,
  input  logic        memR,
  input  logic        memW,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  WBsel,
  input  logic [31:0] D,
  input  logic [31:0] ALUout,
  input  logic [31:0] NPC,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        wb_valid,
  output logic        RegWrite_wb,
  output logic [4:0]  rd_wb,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  localparam int         DEPTH    = 2 ** (ADDR_W - 2);
  localparam logic       HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [3:0] LAT_M1   = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [DEPTH];

  logic              r_wb_valid, r_regwrite_wb, r_misalign_err;
  logic [4:0]        r_rd_wb;
  logic [31:0]       r_wb_data;

  logic [ADDR_W-3:0] w_word_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_rdata, w_load_data, w_wdata, w_wb_mux;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;
  logic              w_mem_op, w_misaligned, w_start_wait;
  logic              w_stall, w_issue, w_complete, w_we;
  logic              w_unused;

  // Upper address bits only alias; fold them here so every ALUout bit is consumed.
  assign w_unused   = ^ALUout;
  assign w_word_idx = ALUout[ADDR_W-1:2];
  assign w_lane     = ALUout[1:0];
  assign w_rdata    = r_mem[w_word_idx];

  assign w_mem_op     = memR | memW;
  assign w_misaligned = w_mem_op & (((size == 2'b01) & w_lane[0]) |
                                    (size[1] & (w_lane != 2'b00)));
  assign w_start_wait = in_valid & w_mem_op & ~w_misaligned & HAS_WAIT;

  assign w_byte = w_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_load_data = w_rdata;
    w_wdata     = D;
    w_be        = 4'b1111;
    case (size)
      2'b00: begin
        w_load_data = {{24{~load_unsigned & w_byte[7]}}, w_byte};
        w_wdata     = {4{D[7:0]}};
        w_be        = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_load_data = {{16{~load_unsigned & w_half[15]}}, w_half};
        w_wdata     = {2{D[15:0]}};
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wb_mux = 32'd0;
    case (WBsel)
      2'b00:   w_wb_mux = ALUout;
      2'b01:   w_wb_mux = w_load_data;
      2'b10:   w_wb_mux = NPC;
      default: w_wb_mux = 32'd0;
    endcase
    if (w_misaligned) w_wb_mux = 32'd0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_wait) begin
          w_stall     = 1'b1;
          w_issue     = 1'b1;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = S_WAIT;
        end else begin
          w_complete  = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = r_cnt - 4'd1;
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stall = w_stall & ~reset;
  assign w_we  = w_complete & in_valid & memW & ~w_misaligned;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid     <= 1'b0;
      r_regwrite_wb  <= 1'b0;
      r_rd_wb        <= 5'd0;
      r_wb_data      <= 32'd0;
      r_misalign_err <= 1'b0;
    end else if (w_issue) begin
      r_wb_valid     <= 1'b0;
    end else if (w_complete) begin
      if (in_valid) begin
        r_wb_valid     <= 1'b1;
        r_regwrite_wb  <= RegWrite_in & ~w_misaligned;
        r_rd_wb        <= rd;
        r_wb_data      <= w_wb_mux;
        r_misalign_err <= w_misaligned;
      end else begin
        r_wb_valid     <= 1'b0;
        r_regwrite_wb  <= 1'b0;
        r_misalign_err <= 1'b0;
      end
    end
  end

  // NOTE: the data array has no reset; its contents must survive a pipeline
  // reset, and leaving it out lets synthesis map it onto a plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_we && w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  assign wb_valid     = r_wb_valid;
  assign RegWrite_wb  = r_regwrite_wb;
  assign rd_wb        = r_rd_wb;
  assign wb_data      = r_wb_data;
  assign misalign_err = r_misalign_err;

endmodule
